// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and load writeback,
// and tracks outstanding load destinations so decode and load issue can stall.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned REG_COUNT = 32,
  localparam int unsigned IW       = $clog2(REG_COUNT)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [IW-1:0]   alu_rd_index,
  input  logic [XLEN-1:0] alu_rd,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [IW-1:0]   ld_rd_index,
  input  logic [XLEN-1:0] ld_rd,
  input  logic            ld_issue,
  input  logic [IW-1:0]   ld_issue_rd_index,
  output logic            ld_issue_ready,
  input  logic [IW-1:0]   rs1_index,
  input  logic [IW-1:0]   rs2_index,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            enable_write_rd,
  output logic [IW-1:0]   rd_index,
  output logic [XLEN-1:0] rd
);

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_LD  = 1'b1
  } grant_t;

  grant_t                last_grant, last_grant_next;
  logic [REG_COUNT-1:0]  scoreboard, scoreboard_next;
  logic                  out_valid;
  logic [IW-1:0]         out_idx;
  logic [XLEN-1:0]       out_data;
  logic                  grant_alu, grant_ld;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant <= GRANT_ALU;
      scoreboard <= '0;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_data   <= '0;
    end else begin
      last_grant <= last_grant_next;
      scoreboard <= scoreboard_next;
      out_valid  <= grant_alu | grant_ld;
      if (grant_ld) begin
        out_idx  <= ld_rd_index;
        out_data <= ld_rd;
      end else if (grant_alu) begin
        out_idx  <= alu_rd_index;
        out_data <= alu_rd;
      end
    end
  end

  always_comb begin
    grant_ld        = 1'b0;
    grant_alu       = 1'b0;
    last_grant_next = last_grant;
    scoreboard_next = scoreboard;

    // Under contention the source not named by last_grant wins.
    grant_ld  = ld_valid & (~alu_valid | (last_grant == GRANT_ALU));
    grant_alu = alu_valid & ~grant_ld;
    if (alu_valid && ld_valid)
      last_grant_next = grant_ld ? GRANT_LD : GRANT_ALU;

    // Clear first so a same-index issue in this cycle overrides it.
    if (grant_ld)
      scoreboard_next[ld_rd_index] = 1'b0;
    if (ld_issue && ld_issue_ready)
      scoreboard_next[ld_issue_rd_index] = 1'b1;
    scoreboard_next[0] = 1'b0;
  end

  assign alu_ready       = grant_alu;
  assign ld_ready        = grant_ld;
  assign ld_issue_ready  = ~scoreboard[ld_issue_rd_index];

  assign rs1_busy = (rs1_index != '0) &
                    (scoreboard[rs1_index] | (out_valid & (out_idx == rs1_index)));
  assign rs2_busy = (rs2_index != '0) &
                    (scoreboard[rs2_index] | (out_valid & (out_idx == rs2_index)));

  assign enable_write_rd = out_valid & (out_idx != '0);
  assign rd_index        = out_idx;
  assign rd              = out_data;

endmodule
